// File: rtl/spkr_smpl_sched_if.sv
// Bus bundle for spkr_smpl_sched.
// Carries the EQ-side input stream, the mute level, the speaker-driver output
// stream and the status outputs.
// master: EQ engine / speaker driver side.  slave: the scheduler.
interface spkr_smpl_sched_if #(
    parameter int DEPTH = 8
);
    logic                     in_vld;
    logic                     in_rdy;
    logic [15:0]              in_lft;
    logic [15:0]              in_rght;
    logic                     mute;
    logic                     vld;
    logic [15:0]              lft_chnnl;
    logic [15:0]              rght_chnnl;
    logic                     underflow;
    logic [$clog2(DEPTH):0]   fifo_cnt;

    modport master (
        output in_vld, in_lft, in_rght, mute,
        input  in_rdy, vld, lft_chnnl, rght_chnnl, underflow, fifo_cnt
    );

    modport slave (
        input  in_vld, in_lft, in_rght, mute,
        output in_rdy, vld, lft_chnnl, rght_chnnl, underflow, fifo_cnt
    );
endinterface

// File: rtl/spkr_smpl_sched.sv
// spkr_smpl_sched: sample-rate scheduler between the EQ engine and spkr_drv.
// Buffers bursty stereo pairs in a small FIFO and releases one pair per
// SMPL_PERIOD clocks as a single-cycle vld pulse. It handles prefill (IDLE),
// starvation recovery (STARVE) and mute.
// Optional feature macro MUTE_RAMP_EN: when defined, mute ramps a gain
// register by one step per tick instead of hard-zeroing the output. It also
// adds the RAMP_SHIFT parameter.
module spkr_smpl_sched #(
    parameter int SMPL_PERIOD = 1024,
`ifdef MUTE_RAMP_EN
    parameter int RAMP_SHIFT  = 8,
`endif
    parameter int DEPTH       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spkr_smpl_sched_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(SMPL_PERIOD);

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DEPTH / 2);
    localparam logic [PW-1:0] PER_LAST  = PW'(SMPL_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STARVE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [PW-1:0]     per_cnt_reg;
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     fifo_cnt_reg;
    logic              vld_reg;
    logic              underflow_reg;
    logic [1:0][15:0]  mem_reg [DEPTH];
    logic [1:0][15:0]  head;

    logic in_rdy;
    logic push;
    logic tick;
    logic pop;

    assign in_rdy = (fifo_cnt_reg != CNT_FULL);
    assign push   = bus.in_vld && in_rdy;
    assign tick   = (state_reg != ST_IDLE) && (per_cnt_reg == PER_LAST);
    // Only RUN pops; an empty RUN tick or any STARVE tick emits silence.
    assign pop    = tick && (state_reg == ST_RUN) && (fifo_cnt_reg != '0);
    assign head   = mem_reg[rd_ptr_reg];

    // Sample storage; index [0] holds left, [1] holds right. No reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {bus.in_rght, bus.in_lft};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // Period counter: parked at 0 while prefilling, free-running otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE || tick) begin
            per_cnt_reg <= '0;
        end else begin
            per_cnt_reg <= per_cnt_reg + 1'b1;
        end
    end

    // Next-state logic. A STARVE tick always emits silence, even when the
    // refill reaches half on that same cycle; RUN then starts one cycle later.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (fifo_cnt_reg >= CNT_HALF) state_next = ST_RUN;
            ST_RUN:    if (tick && fifo_cnt_reg == '0) state_next = ST_STARVE;
            ST_STARVE: if (!tick && fifo_cnt_reg >= CNT_HALF) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register, one-cycle vld strobe and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            vld_reg       <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            vld_reg   <= tick;
            if (tick && state_reg == ST_RUN && fifo_cnt_reg == '0) begin
                underflow_reg <= 1'b1;
            end
        end
    end

`ifdef MUTE_RAMP_EN
    localparam logic [RAMP_SHIFT:0] GAIN_UNITY = {1'b1, {RAMP_SHIFT{1'b0}}};

    logic [RAMP_SHIFT:0] gain_reg, gain_next;

    // Gain steps once per tick toward 0 (muted) or unity (unmuted).
    always_comb begin
        gain_next = gain_reg;
        if (tick) begin
            if (bus.mute) begin
                if (gain_reg != '0) gain_next = gain_reg - 1'b1;
            end else if (gain_reg != GAIN_UNITY) begin
                gain_next = gain_reg + 1'b1;
            end
        end
    end

    // Gain register; the product on a pop already sees the stepped value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_reg <= GAIN_UNITY;
        end else begin
            gain_reg <= gain_next;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chnnl
            logic [15:0] smpl_out;
            logic [15:0] chnnl_reg;
`ifdef MUTE_RAMP_EN
            logic signed [16+RAMP_SHIFT:0] prod;
            logic                          unused_prod_bits;
            // Gain never exceeds unity, so the scaled value always fits 16 bits.
            assign prod             = $signed(head[gi]) * $signed({1'b0, gain_next});
            assign smpl_out         = prod[15+RAMP_SHIFT:RAMP_SHIFT];
            assign unused_prod_bits = ^{prod[16+RAMP_SHIFT], prod[RAMP_SHIFT-1:0]};
`else
            assign smpl_out = bus.mute ? 16'h0000 : head[gi];
`endif
            // Output sample register; it loads only on ticks and holds between vld pulses.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    chnnl_reg <= '0;
                end else if (tick) begin
                    chnnl_reg <= pop ? smpl_out : 16'h0000;
                end
            end
        end
    endgenerate

    assign bus.in_rdy     = in_rdy;
    assign bus.vld        = vld_reg;
    assign bus.lft_chnnl  = g_chnnl[0].chnnl_reg;
    assign bus.rght_chnnl = g_chnnl[1].chnnl_reg;
    assign bus.underflow  = underflow_reg;
    assign bus.fifo_cnt   = fifo_cnt_reg;
endmodule
